// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell is stepped LSB-first through a carry flop.
// Optional signed-overflow output is enabled with `define SERIAL_ADDER_OVF_EN.

module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             overflow
`endif
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh, b_sh, sum_q, sum_nx;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             cell_s, cell_co;
  logic             last, accept;

  full_adder_cell u_cell (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry_q),
    .s  (cell_s),
    .co (cell_co)
  );

  assign last   = (cnt_q == CW'(WIDTH - 1));
  assign accept = in_valid & in_ready;

  // Sum bits enter from the MSB side so that after WIDTH shifts bit 0 lands at SUM[0].
  generate
    if (WIDTH == 1) begin : g_sum_w1
      assign sum_nx = cell_s;
    end else begin : g_sum_wn
      assign sum_nx = {cell_s, sum_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_RUN;
      S_RUN:   if (last) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      S_IDLE:  in_ready  = 1'b1;
      S_RUN:   busy      = 1'b1;
      S_DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          a_sh    <= a;
          b_sh    <= b;
          carry_q <= carry_in;
          cnt_q   <= '0;
        end
        S_RUN: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          sum_q   <= sum_nx;
          carry_q <= cell_co;
          if (!last) cnt_q <= cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  // Signed overflow: carry into the sign bit differs from carry out of it.
  logic ovf_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         ovf_q <= 1'b0;
    else if (state_q == S_IDLE && accept) ovf_q <= 1'b0;
    else if (state_q == S_RUN && last)    ovf_q <= carry_q ^ cell_co;
  end
  assign overflow = ovf_q;
`endif

  assign sum       = sum_q;
  assign carry_out = carry_q;

endmodule
